// File: rtl/p_hit_arbiter.sv
// Round-robin share of one p_hit datapath between two requesters.
// A 1-bit tag FIFO routes each in-order p_hit result back to its owner.
module p_hit_arbiter #(
    parameter int TAG_DEPTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                req_empty,
    output logic [1:0]                req_rd_en,
    input  logic signed [1:0][2:0][31:0] req_tri_normal_1,
    input  logic signed [1:0][2:0][31:0] req_tri_normal_2,
    input  logic signed [1:0][2:0][31:0] req_v0,
    input  logic signed [1:0][2:0][31:0] req_origin,
    input  logic signed [1:0][2:0][31:0] req_dir,
    output logic signed [2:0][31:0]   ph_tri_normal_1,
    output logic signed [2:0][31:0]   ph_tri_normal_2,
    output logic signed [2:0][31:0]   ph_v0,
    output logic signed [2:0][31:0]   ph_origin,
    output logic signed [2:0][31:0]   ph_dir,
    input  logic [3:0]                ph_in_full,
    output logic [3:0]                ph_in_wr_en,
    input  logic signed [2:0][31:0]   ph_out,
    input  logic                      ph_out_empty,
    output logic                      ph_out_rd_en,
    output logic signed [1:0][2:0][31:0] res_out,
    output logic [1:0]                res_empty,
    input  logic [1:0]                res_rd_en,
    output logic [$clog2(TAG_DEPTH):0] outstanding,
    output logic                      err
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic                  prio_q, prio_d;
    logic [TAG_DEPTH-1:0]  tag_q, tag_d;
    logic [AW-1:0]         wp_q, wp_d;
    logic [AW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [1:0][2:0][31:0] res_q, res_d;
    logic [1:0]            remp_q, remp_d;
    logic                  err_q, err_d;

    logic can_issue;
    logic issue;
    logic g;
    logic sel;
    logic t;
    logic pop;

    always_comb begin
        can_issue = (ph_in_full == 4'b0000) &&
                    (cnt_q < CW'(TAG_DEPTH)) && !reset;
        g     = req_empty[prio_q] ? ~prio_q : prio_q;
        issue = can_issue && (req_empty != 2'b11);
        sel   = issue ? g : prio_q;

        req_rd_en = 2'b00;
        if (issue) req_rd_en[g] = 1'b1;
        ph_in_wr_en = {4{issue}};

        ph_tri_normal_1 = req_tri_normal_1[sel];
        ph_tri_normal_2 = req_tri_normal_2[sel];
        ph_v0           = req_v0[sel];
        ph_origin       = req_origin[sel];
        ph_dir          = req_dir[sel];

        t   = tag_q[rp_q];
        pop = !ph_out_empty && (cnt_q != '0) &&
              (remp_q[t] || res_rd_en[t]);
        ph_out_rd_en = pop;
    end

    always_comb begin
        prio_d = issue ? ~g : prio_q;
        tag_d  = tag_q;
        if (issue) tag_d[wp_q] = g;
        wp_d   = wp_q + AW'(issue);
        rp_d   = rp_q + AW'(pop);
        cnt_d  = cnt_q + CW'(issue) - CW'(pop);

        res_d  = res_q;
        remp_d = remp_q;
        for (int r = 0; r < 2; r++) begin
            if (res_rd_en[r]) remp_d[r] = 1'b1;
        end
        // A refill wins over a same-cycle read of the slot.
        if (pop) begin
            res_d[t]  = ph_out;
            remp_d[t] = 1'b0;
        end

        err_d = err_q | (!ph_out_empty && (cnt_q == '0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
            tag_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            remp_q <= 2'b11;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            tag_q  <= tag_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            remp_q <= remp_d;
            err_q  <= err_d;
        end
    end

    assign outstanding = cnt_q;
    assign res_out     = res_q;
    assign res_empty   = remp_q;
    assign err         = err_q;

endmodule
